// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration sequencer.
//
// Contents:
//   ADDR_W, DATA_W, CMD_W  - field widths of one write command
//   DEFAULT_SLAVE_ADDR     - 8-bit write address of the HDMI transmitter
//   cfgState_t             - sequencer state encoding
//   packCmd()              - assembles {slave addr, reg addr, data}
package i2c_cfg_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 24;

  localparam logic [ADDR_W-1:0] DEFAULT_SLAVE_ADDR = 8'h72;

  typedef enum logic [2:0] {
    IDLE,
    POWER_WAIT,
    LOAD,
    ISSUE,
    WAIT_BUSY,
    NEXT,
    DONE,
    ERROR
  } cfgState_t;

  function automatic logic [CMD_W-1:0] packCmd(
    input logic [ADDR_W-1:0] slaveAddr,
    input logic [ADDR_W-1:0] regAddr,
    input logic [DATA_W-1:0] data
  );
    return {slaveAddr, regAddr, data};
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// HDMI transmitter init table with a registered read port.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset, clears the output register
//   en       in   capture the entry addressed by index at this edge
//   index    in   8-bit table index
//   entry    out  24-bit {slave addr, reg addr, data}; 0 for an index
//                 at or beyond NUM_ENTRIES or past the end of the table
module i2c_config_rom
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [7:0]       index,
  output logic [CMD_W-1:0] entry
);

  // Power-up and basic video setup for the transmitter at 0x72.
  function automatic logic [CMD_W-1:0] tableLookup(input logic [7:0] idx);
    case (idx)
      8'd0:    return packCmd(DEFAULT_SLAVE_ADDR, 8'h41, 8'h10);
      8'd1:    return packCmd(DEFAULT_SLAVE_ADDR, 8'h98, 8'h03);
      8'd2:    return packCmd(DEFAULT_SLAVE_ADDR, 8'h9A, 8'hE0);
      8'd3:    return packCmd(DEFAULT_SLAVE_ADDR, 8'h9C, 8'h30);
      8'd4:    return packCmd(DEFAULT_SLAVE_ADDR, 8'h9D, 8'h61);
      8'd5:    return packCmd(DEFAULT_SLAVE_ADDR, 8'hA2, 8'hA4);
      8'd6:    return packCmd(DEFAULT_SLAVE_ADDR, 8'hA3, 8'hA4);
      8'd7:    return packCmd(DEFAULT_SLAVE_ADDR, 8'hE0, 8'hD0);
      8'd8:    return packCmd(DEFAULT_SLAVE_ADDR, 8'hF9, 8'h00);
      8'd9:    return packCmd(DEFAULT_SLAVE_ADDR, 8'h15, 8'h00);
      8'd10:   return packCmd(DEFAULT_SLAVE_ADDR, 8'h16, 8'h30);
      8'd11:   return packCmd(DEFAULT_SLAVE_ADDR, 8'h17, 8'h00);
      8'd12:   return packCmd(DEFAULT_SLAVE_ADDR, 8'h18, 8'h46);
      8'd13:   return packCmd(DEFAULT_SLAVE_ADDR, 8'hAF, 8'h06);
      8'd14:   return packCmd(DEFAULT_SLAVE_ADDR, 8'hD6, 8'hC0);
      8'd15:   return packCmd(DEFAULT_SLAVE_ADDR, 8'h55, 8'h10);
      default: return '0;
    endcase
  endfunction

  // Only updates when enabled so the command stays stable between lookups.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry <= '0;
    end else if (en) begin
      entry <= (int'(index) < NUM_ENTRIES) ? tableLookup(index) : '0;
    end
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the HDMI transmitter init table and drives the I2C write engine
// through a go/busy/nack handshake, one 24-bit command at a time.
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   start          level request for a configuration run, honoured in IDLE
//   i2c_cmd        {slave addr, reg addr, data} for the current entry
//   i2c_go         transaction request, held until the engine reports busy
//   i2c_busy       engine mid-transaction
//   i2c_nack       engine ack result, sampled when i2c_busy falls
//   busy           run in progress
//   config_done    sticky, whole table written
//   config_error   sticky, NACK or transaction timeout
//   entry_index    current or last (failing) entry
//
// Build option: define I2C_CFG_RETRY_EN to retry a NACKed entry up to
// RETRY_LIMIT times before flagging an error. Timeouts never retry.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int POWERUP_WAIT   = 1000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int RETRY_LIMIT    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [CMD_W-1:0] i2c_cmd,
  output logic             i2c_go,
  input  logic             i2c_busy,
  input  logic             i2c_nack,
  output logic             busy,
  output logic             config_done,
  output logic             config_error,
  output logic [7:0]       entry_index
);

  localparam int WAIT_W = (POWERUP_WAIT < 2) ? 1 : $clog2(POWERUP_WAIT);
  localparam int TO_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [WAIT_W-1:0] WAIT_LAST  =
    (POWERUP_WAIT < 1) ? '0 : WAIT_W'(POWERUP_WAIT - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        LAST_INDEX = 8'(NUM_ENTRIES - 1);

  cfgState_t         state;
  logic [WAIT_W-1:0] waitCnt;
  logic [TO_W-1:0]   toCnt;
  logic              romEn;

`ifdef I2C_CFG_RETRY_EN
  localparam int RETRY_W = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_LIMIT);
  logic [RETRY_W-1:0] retryCnt;
`endif

  // The ROM register is the command register: it is loaded only in LOAD.
  assign romEn = (state == LOAD);

  i2c_config_rom #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) uRom (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (romEn),
    .index  (entry_index),
    .entry  (i2c_cmd)
  );

  // Done/error/busy are updated on the transition into DONE/ERROR, so
  // those states only spend one cycle before returning to IDLE. The
  // timeout counter runs across ISSUE and WAIT_BUSY and expires on the
  // TIMEOUT_CYCLES-th edge after entering ISSUE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      waitCnt      <= '0;
      toCnt        <= '0;
      i2c_go       <= 1'b0;
      busy         <= 1'b0;
      config_done  <= 1'b0;
      config_error <= 1'b0;
      entry_index  <= '0;
`ifdef I2C_CFG_RETRY_EN
      retryCnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            config_done  <= 1'b0;
            config_error <= 1'b0;
            entry_index  <= '0;
            busy         <= 1'b1;
            waitCnt      <= '0;
            state        <= POWER_WAIT;
          end
        end

        POWER_WAIT: begin
          if (POWERUP_WAIT == 0 || waitCnt == WAIT_LAST) begin
            state <= LOAD;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        LOAD: begin
          toCnt  <= '0;
          i2c_go <= 1'b1;
          state  <= ISSUE;
`ifdef I2C_CFG_RETRY_EN
          retryCnt <= '0;
`endif
        end

        ISSUE: begin
          if (toCnt == TO_LAST) begin
            i2c_go       <= 1'b0;
            config_error <= 1'b1;
            busy         <= 1'b0;
            state        <= ERROR;
          end else begin
            toCnt <= toCnt + 1'b1;
            if (i2c_busy) begin
              i2c_go <= 1'b0;
              state  <= WAIT_BUSY;
            end
          end
        end

        WAIT_BUSY: begin
          if (toCnt == TO_LAST) begin
            config_error <= 1'b1;
            busy         <= 1'b0;
            state        <= ERROR;
          end else if (!i2c_busy) begin
            if (!i2c_nack) begin
              state <= NEXT;
`ifdef I2C_CFG_RETRY_EN
            end else if (retryCnt < RETRY_LAST) begin
              retryCnt <= retryCnt + 1'b1;
              toCnt    <= '0;
              i2c_go   <= 1'b1;
              state    <= ISSUE;
`endif
            end else begin
              config_error <= 1'b1;
              busy         <= 1'b0;
              state        <= ERROR;
            end
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end

        NEXT: begin
          if (entry_index == LAST_INDEX) begin
            config_done <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            entry_index <= entry_index + 1'b1;
            state       <= LOAD;
          end
        end

        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Self-checking bench for i2c_config_sequencer with a small behavioural
// I2C engine and a table-walk reference model. Expectations for NACK
// handling follow I2C_CFG_RETRY_EN when it is defined for the build.
module tb_i2c_config_sequencer;

  localparam int NUM_ENTRIES    = 4;
  localparam int POWERUP_WAIT   = 10;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int RETRY_LIMIT    = 3;
`ifdef I2C_CFG_RETRY_EN
  localparam int MODEL_RETRIES  = RETRY_LIMIT;
`else
  localparam int MODEL_RETRIES  = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] i2c_cmd;
  logic        i2c_go;
  logic        i2c_busy;
  logic        i2c_nack;
  logic        busy;
  logic        config_done;
  logic        config_error;
  logic [7:0]  entry_index;

  int checks   = 0;
  int failures = 0;

  logic [23:0] hdmiTable [0:15] = '{
    24'h724110, 24'h729803, 24'h729AE0, 24'h729C30,
    24'h729D61, 24'h72A2A4, 24'h72A3A4, 24'h72E0D0,
    24'h72F900, 24'h721500, 24'h721630, 24'h721700,
    24'h721846, 24'h72AF06, 24'h72D6C0, 24'h725510
  };

  int          nackPlan     [NUM_ENTRIES];
  int          attemptsSeen [NUM_ENTRIES];
  logic [23:0] expCmdQ [$];
  logic        expDone;
  logic        expError;
  logic [7:0]  expIndex;
  int          goSeen;
  int          lastGoWait;

  i2c_config_sequencer #(
    .NUM_ENTRIES   (NUM_ENTRIES),
    .POWERUP_WAIT  (POWERUP_WAIT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .RETRY_LIMIT   (RETRY_LIMIT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .i2c_cmd     (i2c_cmd),
    .i2c_go      (i2c_go),
    .i2c_busy    (i2c_busy),
    .i2c_nack    (i2c_nack),
    .busy        (busy),
    .config_done (config_done),
    .config_error(config_error),
    .entry_index (entry_index)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: each entry is attempted until it is ACKed or its
  // NACKs exceed the retry allowance; the run stops at the first failure.
  task automatic buildModel();
    int attempts;
    expCmdQ.delete();
    expDone  = 1'b0;
    expError = 1'b0;
    expIndex = 8'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      attempts = (nackPlan[i] > MODEL_RETRIES) ? MODEL_RETRIES + 1 : nackPlan[i] + 1;
      for (int a = 0; a < attempts; a++) expCmdQ.push_back(hdmiTable[i]);
      expIndex = 8'(i);
      if (nackPlan[i] > MODEL_RETRIES) begin
        expError = 1'b1;
        break;
      end
    end
    expDone = !expError;
  endtask

  function automatic int findEntry(input logic [23:0] cmd);
    for (int i = 0; i < NUM_ENTRIES; i++) if (hdmiTable[i] == cmd) return i;
    return -1;
  endfunction

  task automatic clearEngine();
    goSeen = 0;
    for (int i = 0; i < NUM_ENTRIES; i++) attemptsSeen[i] = 0;
  endtask

  task automatic applyStimulus();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Engine model for one transaction: wait for go, acknowledge with busy,
  // then finish with the NACK/ACK the plan calls for.
  task automatic doTransaction(output bit found);
    int  waited;
    int  e;
    bit  nackIt;
    found  = 1'b0;
    waited = 0;
    while (!i2c_go && busy && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    lastGoWait = waited;
    if (waited >= 300) begin
      checkOutput("goWaitBound", 32'(i2c_go), 1);
      return;
    end
    if (!i2c_go) return;
    found = 1'b1;
    if (goSeen < expCmdQ.size()) checkOutput("cmd", 32'(i2c_cmd), 32'(expCmdQ[goSeen]));
    else checkOutput("extraGo", goSeen, expCmdQ.size());
    e      = findEntry(i2c_cmd);
    nackIt = (e >= 0) && (attemptsSeen[e] < nackPlan[e]);
    if (e >= 0) attemptsSeen[e]++;
    goSeen++;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    i2c_busy = 1'b1;
    @(negedge clk);
    checkOutput("goRelease", 32'(i2c_go), 0);
    repeat ($urandom_range(3, 15)) @(negedge clk);
    i2c_nack = nackIt;
    i2c_busy = 1'b0;
    @(negedge clk);
    i2c_nack = 1'b0;
  endtask

  task automatic serviceRun(input bit watchTail, output int firstWait);
    bit found;
    int extra;
    clearEngine();
    found     = 1'b1;
    firstWait = -1;
    for (int t = 0; t < 64 && found; t++) begin
      doTransaction(found);
      if (t == 0) firstWait = lastGoWait;
    end
    checkOutput("goCount",     goSeen, expCmdQ.size());
    checkOutput("configDone",  32'(config_done), 32'(expDone));
    checkOutput("configError", 32'(config_error), 32'(expError));
    checkOutput("entryIndex",  32'(entry_index), 32'(expIndex));
    checkOutput("busyAtEnd",   32'(busy), 0);
    if (watchTail) begin
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (i2c_go) extra++;
      end
      checkOutput("tailGo", extra, 0);
    end
  endtask

  task automatic clearPlan();
    for (int i = 0; i < NUM_ENTRIES; i++) nackPlan[i] = 0;
  endtask

  initial begin
    int  firstWait;
    int  waited;
    int  cnt;
    bit  found;

    reset_n  = 1'b0;
    start    = 1'b0;
    i2c_busy = 1'b0;
    i2c_nack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstCmd",   32'(i2c_cmd), 0);
    checkOutput("rstGo",    32'(i2c_go), 0);
    checkOutput("rstBusy",  32'(busy), 0);
    checkOutput("rstDone",  32'(config_done), 0);
    checkOutput("rstError", 32'(config_error), 0);
    checkOutput("rstIndex", 32'(entry_index), 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed full run");
    clearPlan();
    buildModel();
    applyStimulus();
    serviceRun(1'b1, firstWait);
    checkOutput("firstGoLatency", 32'((firstWait + 1 >= 11) && (firstWait + 1 <= 12)), 1);

    $display("[TB] NACK on entry 2");
    clearPlan();
    nackPlan[2] = 1;
    buildModel();
    applyStimulus();
    serviceRun(1'b1, firstWait);

    $display("[TB] entry 1 NACKed twice then ACKed");
    clearPlan();
    nackPlan[1] = 2;
    buildModel();
    applyStimulus();
    serviceRun(1'b1, firstWait);

    $display("[TB] entry 1 NACKed four times");
    clearPlan();
    nackPlan[1] = 4;
    buildModel();
    applyStimulus();
    serviceRun(1'b1, firstWait);

    $display("[TB] engine never responds");
    applyStimulus();
    waited = 0;
    while (!i2c_go && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("toGoSeen", 32'(i2c_go), 1);
    cnt = 0;
    while (i2c_go && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("toCycles", cnt, TIMEOUT_CYCLES);
    checkOutput("toError",  32'(config_error), 1);
    checkOutput("toDone",   32'(config_done), 0);
    checkOutput("toIndex",  32'(entry_index), 0);
    checkOutput("toBusy",   32'(busy), 0);

    $display("[TB] reset during entry 1");
    clearPlan();
    buildModel();
    clearEngine();
    applyStimulus();
    doTransaction(found);
    waited = 0;
    while (!i2c_go && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rstE1Cmd", 32'(i2c_cmd), 32'(hdmiTable[1]));
    i2c_busy = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstGo",    32'(i2c_go), 0);
    checkOutput("midRstBusy",  32'(busy), 0);
    checkOutput("midRstIndex", 32'(entry_index), 0);
    checkOutput("midRstDone",  32'(config_done), 0);
    reset_n  = 1'b1;
    i2c_busy = 1'b0;
    applyStimulus();
    serviceRun(1'b1, firstWait);

    $display("[TB] start held high");
    clearPlan();
    buildModel();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    serviceRun(1'b0, firstWait);
    cnt = 0;
    while (!busy && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("heldRestart",   32'(busy), 1);
    checkOutput("heldDoneClear", 32'(config_done), 0);
    start = 1'b0;
    serviceRun(1'b1, firstWait);

    $display("[TB] randomized runs");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        nackPlan[i] = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
      buildModel();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      applyStimulus();
      serviceRun(1'b1, firstWait);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
